pixel_out_buffer: RTL and testbench
===================================

Name: pixel_out_buffer

Overview:
- Downstream stage of the renderer. Consumes the renderer's pixel AXI-stream and drives the VGA pins in lock-step with the raster timing from vga_sig_gen.
- A small FIFO absorbs renderer jitter and back-pressure. This replaces the fixed-latency sync delay pipes.
- A frame-alignment FSM only starts draining at raster origin (0,0). It resynchronises automatically after underflow or misalignment.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- DATA_W, 24, pixel width; packing is {red[7:0], green[7:0], blue[7:0]}.

Ports:
- pixel_clk_in  in  1  pixel clock; the only clock.
- rst_in  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  DATA_W  renderer pixel.
- s_axis_tuser  in  1  start-of-frame; high on the pixel for h=0, v=0.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  buffer can accept.
- hcount_in  in  11  raster x from vga_sig_gen.
- vcount_in  in  10  raster y from vga_sig_gen.
- ad_in  in  1  active draw.
- hs_in  in  1  hsync.
- vs_in  in  1  vsync.
- vga_r_out  out  4  red.
- vga_g_out  out  4  green.
- vga_b_out  out  4  blue.
- vga_hs_out  out  1  delayed hsync.
- vga_vs_out  out  1  delayed vsync.
- underflow_out  out  1  sticky error flag.
- locked_out  out  1  high while in RUN.

Behaviour:
- Reset (async, rst_in=1):
  - Pointers clear; FSM enters HUNT.
  - All outputs are 0, including s_axis_tready, underflow_out and locked_out.
  - Release is synchronous to the next clock edge.
- FIFO storage:
  - Circular buffer of DEPTH x (DATA_W+1); each entry holds {tuser, tdata}.
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB disambiguates full from empty.
  - s_axis_tready = !full, combinational from registered pointers.
  - Push when tvalid && tready. When full, no push occurs even if a pop happens the same cycle.
  - No write-to-read bypass: a pixel pushed in cycle N is poppable in cycle N+1 at the earliest.
- FSM states:
  - HUNT:
    - tready=1. Incoming beats with tuser=0 are accepted and discarded (not written).
    - A beat with tuser=1 is written → WAIT_ORIGIN.
  - WAIT_ORIGIN:
    - Normal FIFO pushes continue; no pops.
    - When ad_in && hcount_in==0 && vcount_in==0 && !empty → RUN, and this cycle pops.
    - If the FIFO is empty at origin, stay and retry next frame.
  - RUN:
    - Every cycle with ad_in=1 pops one entry. Cycles with ad_in=0 never pop.
    - Pop while empty: output black, set underflow_out, flush (rd_ptr<=wr_ptr) → HUNT.
    - Popped entry has tuser=1 but raster is not (0,0): misalignment. Output black, set underflow_out, flush → HUNT.
    - Popped entry has tuser=0 at raster (0,0): same misalignment handling.
- Output timing:
  - Exactly 1 cycle of latency from the raster inputs to the VGA outputs.
  - vga_hs_out and vga_vs_out are hs_in/vs_in registered once, in every state.
  - Colour registers take popped tdata bits [23:20], [15:12], [7:4] when a successful pop occurs in RUN; otherwise 0.
  - locked_out is registered (state==RUN).
- underflow_out is sticky until reset.
- Simultaneous push and pop in RUN are both honoured; occupancy is unchanged.
- Reset mid-frame: immediate blanking, FIFO contents lost, restart in HUNT.

Decomposition:
- Shared package pixel_pkg:
  - typedef pixel_t (24-bit {r,g,b});
  - fsm enum buf_state_t {HUNT, WAIT_ORIGIN, RUN};
  - constants H_ACTIVE=1024, V_ACTIVE=768 for bench use.
- One sub-module, pixel_fifo:
  - parameterised DEPTH/WIDTH;
  - ports push, pop, din, dout, full, empty, flush;
  - combinational read of the head entry.
- FSM and output registers live in pixel_out_buffer.

Test Plan:
- Reset: assert rst_in mid-RUN with FIFO holding 5 entries → same-cycle outputs 0, tready=0. One cycle after release, tready=1 and state is HUNT.
- Lock: feed 3 non-SOF beats, then SOF 0xFF0000 followed by a 0x00FF00 stream, raster reaching (0,0) afterwards → first 3 beats are dropped. One cycle after (0,0), vga_r_out=0xF, locked_out=1. Next active pixel gives vga_g_out=0xF.
- Back-pressure: stall pops (ad_in=0) with tvalid=1 continuous → exactly DEPTH=16 pushes, tready=0. One pop plus offered push the same cycle → no push that cycle; push accepted the next cycle.
- Underflow: in RUN, stop tvalid after 10 pixels while ad_in stays high → pixel 11 outputs black, underflow_out=1 (sticky), locked_out drops. Relock occurs at the next SOF plus origin.
- Misalignment: inject SOF at pixel index 500 of a line → that cycle outputs black, underflow_out=1, FIFO flushed (empty=1), state HUNT.
- Sync delay: toggle hs_in/vs_in in every state → vga_hs_out/vga_vs_out equal the inputs delayed exactly 1 cycle.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types for the pixel output path: packed RGB pixel, buffer FSM states, raster size.
// Latency: none (types only). Backpressure: n/a.
package pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    HUNT        = 2'd0,
    WAIT_ORIGIN = 2'd1,
    RUN         = 2'd2
  } buf_state_t;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

endpackage

// File: rtl/pixel_fifo.sv
// Circular FIFO with extra-MSB pointers, combinational head read and a flush that empties it.
// Latency: push visible at head next cycle. Backpressure: full_o blocks pushes; flush drops a same-cycle push.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    // Flush discards everything including a beat offered in the same cycle.
    if (flush_i)     rd_d = wr_q;
    else if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pixel_out_buffer.sv
// Buffers renderer pixels and drains them in lock-step with raster timing, aligned on SOF at origin.
// Latency: 1 cycle raster-in to VGA-out. Backpressure: s_axis_tready = !full (0 during reset).
module pixel_out_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              ad_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [3:0]        vga_r_out,
  output logic [3:0]        vga_g_out,
  output logic [3:0]        vga_b_out,
  output logic              vga_hs_out,
  output logic              vga_vs_out,
  output logic              underflow_out,
  output logic              locked_out
);

  buf_state_t      state_q, state_d;
  logic            rdy_en_q;
  logic [3:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic            hs_q, vs_q, und_q, lock_q;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [DATA_W:0] head;
  pixel_t          head_px;
  logic            head_sof;
  logic            at_origin;
  logic            beat;
  logic            pop_ok;
  logic            pop_err;
  logic            unused_px;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk_i   (pixel_clk_in),
    .rst_i   (rst_in),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .din_i   ({s_axis_tuser, s_axis_tdata}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // rdy_en_q keeps tready low while reset is held and for the release edge.
  assign s_axis_tready = rdy_en_q && !fifo_full;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign at_origin     = ad_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign head_sof      = head[DATA_W];
  assign head_px       = pixel_t'(head[DATA_W-1:0]);
  assign unused_px     = ^{head_px.r[3:0], head_px.g[3:0], head_px.b[3:0]};

  always_comb begin
    state_d    = state_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    pop_ok     = 1'b0;
    pop_err    = 1'b0;
    case (state_q)
      HUNT: begin
        if (beat && s_axis_tuser) begin
          fifo_push = 1'b1;
          state_d   = WAIT_ORIGIN;
        end
      end
      WAIT_ORIGIN: begin
        fifo_push = beat;
        if (at_origin && !fifo_empty) begin
          pop_ok  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        fifo_push = beat;
        if (ad_in) begin
          // SOF must land exactly on the origin pixel, and nowhere else.
          if (fifo_empty || (head_sof != at_origin)) begin
            pop_err    = 1'b1;
            fifo_flush = 1'b1;
            state_d    = HUNT;
          end else begin
            pop_ok = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    fifo_pop = pop_ok;
    r_d      = pop_ok ? head_px.r[7:4] : 4'd0;
    g_d      = pop_ok ? head_px.g[7:4] : 4'd0;
    b_d      = pop_ok ? head_px.b[7:4] : 4'd0;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= HUNT;
      rdy_en_q <= 1'b0;
      r_q      <= 4'd0;
      g_q      <= 4'd0;
      b_q      <= 4'd0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      und_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hs_q     <= hs_in;
      vs_q     <= vs_in;
      und_q    <= und_q | pop_err;
      lock_q   <= (state_d == RUN);
    end
  end

  assign vga_r_out     = r_q;
  assign vga_g_out     = g_q;
  assign vga_b_out     = b_q;
  assign vga_hs_out    = hs_q;
  assign vga_vs_out    = vs_q;
  assign underflow_out = und_q;
  assign locked_out    = lock_q;

endmodule

// File: tb/tb_pixel_out_buffer.sv
// Directed bench for pixel_out_buffer: lock vector table, then hand sequences for
// underflow, relock, back-pressure, mid-run reset and misalignment.
module tb_pixel_out_buffer;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        ad_in, hs_in, vs_in;
  logic [3:0]  vga_r_out, vga_g_out, vga_b_out;
  logic        vga_hs_out, vga_vs_out, underflow_out, locked_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_out_buffer #(.DEPTH(16), .DATA_W(24)) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_in),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .ad_in         (ad_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .vga_r_out     (vga_r_out),
    .vga_g_out     (vga_g_out),
    .vga_b_out     (vga_b_out),
    .vga_hs_out    (vga_hs_out),
    .vga_vs_out    (vga_vs_out),
    .underflow_out (underflow_out),
    .locked_out    (locked_out)
  );

  typedef struct {
    logic        tv;
    logic        tu;
    logic [23:0] dat;
    logic        ad;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        und;
    logic        lock;
    logic        rdy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic h, v;
    h = hs_in;
    v = vs_in;
    @(posedge clk);
    #1;
    if (!rst_in) begin
      chk("hs_delay", 32'(vga_hs_out), 32'(h));
      chk("vs_delay", 32'(vga_vs_out), 32'(v));
    end
  endtask

  task automatic drive(input logic tv, input logic tu, input logic [23:0] dat,
                       input logic ad, input logic [10:0] h, input logic [9:0] v);
    s_axis_tvalid = tv;
    s_axis_tuser  = tu;
    s_axis_tdata  = dat;
    ad_in         = ad;
    hcount_in     = h;
    vcount_in     = v;
    hs_in         = 1'($urandom_range(0, 1));
    vs_in         = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_pix(input string name, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic und, input logic lock);
    chk({name, "_r"}, 32'(vga_r_out), 32'(r));
    chk({name, "_g"}, 32'(vga_g_out), 32'(g));
    chk({name, "_b"}, 32'(vga_b_out), 32'(b));
    chk({name, "_und"}, 32'(underflow_out), 32'(und));
    chk({name, "_lock"}, 32'(locked_out), 32'(lock));
  endtask

  function automatic vec_t mk(input logic tv, input logic tu, input logic [23:0] dat,
                              input logic ad, input logic [10:0] h, input logic [9:0] v,
                              input logic hs, input logic vs, input logic [3:0] r,
                              input logic [3:0] g, input logic [3:0] b, input logic lock);
    vec_t t;
    t.tv = tv; t.tu = tu; t.dat = dat; t.ad = ad; t.h = h; t.v = v;
    t.hs = hs; t.vs = vs; t.r = r; t.g = g; t.b = b;
    t.und = 1'b0; t.lock = lock; t.rdy = 1'b1;
    return t;
  endfunction

  function automatic logic [23:0] pat(input int k);
    logic [3:0] n;
    n = k[3:0];
    return {n, 4'h0, ~n, 4'h0, n, 4'h0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pushes;
    logic [3:0] n;

    // Lock sequence: three non-SOF beats dropped, SOF red, then green stream.
    vecs[0]  = mk(1'b0, 1'b0, 24'h000000, 1'b0, 11'd1000, 10'd767, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 24'h123456, 1'b0, 11'd1001, 10'd767, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 24'hABCDEF, 1'b0, 11'd1002, 10'd767, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 24'hFFFFFF, 1'b0, 11'd1003, 10'd767, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 24'hFF0000, 1'b0, 11'd1004, 10'd767, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 24'h00FF00, 1'b0, 11'd1005, 10'd767, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 24'h00FF00, 1'b0, 11'd1006, 10'd767, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 24'h00FF00, 1'b1, 11'd0,    10'd0,   1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 24'h00FF00, 1'b1, 11'd1,    10'd0,   1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 24'h00FF00, 1'b0, 11'd2,    10'd0,   1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 24'h00FF00, 1'b1, 11'd2,    10'd0,   1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 1'b1);

    rst_in = 1'b1;
    drive(1'b0, 1'b0, 24'h0, 1'b0, 11'd0, 10'd0);
    hs_in = 1'b1;
    vs_in = 1'b1;
    #2;
    chk_pix("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("reset_tready", 32'(s_axis_tready), 32'd0);
    chk("reset_hs", 32'(vga_hs_out), 32'd0);
    tick();
    tick();
    rst_in = 1'b0;

    for (int i = 0; i < 11; i++) begin
      s_axis_tvalid = vecs[i].tv;
      s_axis_tuser  = vecs[i].tu;
      s_axis_tdata  = vecs[i].dat;
      ad_in         = vecs[i].ad;
      hcount_in     = vecs[i].h;
      vcount_in     = vecs[i].v;
      hs_in         = vecs[i].hs;
      vs_in         = vecs[i].vs;
      tick();
      chk_pix($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].und, vecs[i].lock);
      chk($sformatf("vec%0d_hs", i), 32'(vga_hs_out), 32'(vecs[i].hs));
      chk($sformatf("vec%0d_vs", i), 32'(vga_vs_out), 32'(vecs[i].vs));
      chk($sformatf("vec%0d_rdy", i), 32'(s_axis_tready), 32'(vecs[i].rdy));
    end

    // Underflow: 4 green pixels remain, tvalid stops, fifth active pixel underflows.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 24'h0, 1'b1, 11'(3 + i), 10'd0);
      tick();
      chk_pix("underflow_drain", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 24'h0, 1'b1, 11'd7, 10'd0);
    tick();
    chk_pix("underflow_hit", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 24'h0, 1'b0, 11'd8, 10'd0);
    tick();
    chk_pix("underflow_sticky", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Relock: stray beat dropped in HUNT, SOF blue, then origin.
    drive(1'b1, 1'b0, 24'h00FF00, 1'b0, 11'd9, 10'd0);
    tick();
    drive(1'b1, 1'b1, 24'h0000FF, 1'b0, 11'd10, 10'd0);
    tick();
    chk("relock_wait_lock", 32'(locked_out), 32'd0);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 11'd0, 10'd0);
    tick();
    chk_pix("relock", 4'h0, 4'h0, 4'hF, 1'b1, 1'b1);

    // Back-pressure: no pops, continuous offer; exactly DEPTH beats accepted.
    pushes = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, pat(k), 1'b0, 11'd50, 10'd5);
      if (s_axis_tready) pushes++;
      tick();
    end
    chk("bp_push_count", 32'(pushes), 32'd16);
    chk("bp_full_tready", 32'(s_axis_tready), 32'd0);
    drive(1'b1, 1'b0, pat(20), 1'b1, 11'd100, 10'd5);
    chk("bp_pop_cycle_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk_pix("bp_pop", 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    chk("bp_after_pop_tready", 32'(s_axis_tready), 32'd1);
    drive(1'b1, 1'b0, pat(21), 1'b0, 11'd101, 10'd5);
    tick();
    chk("bp_refill_tready", 32'(s_axis_tready), 32'd0);

    // Drain 11 entries in order, leaving 5 in the FIFO.
    for (int k = 1; k <= 11; k++) begin
      n = 4'(k);
      drive(1'b0, 1'b0, 24'h0, 1'b1, 11'(101 + k), 10'd5);
      tick();
      chk_pix($sformatf("drain%0d", k), n, ~n, n, 1'b1, 1'b1);
    end

    // Asynchronous reset mid-run.
    hs_in = 1'b1;
    vs_in = 1'b1;
    rst_in = 1'b1;
    #2;
    chk_pix("midrst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("midrst_tready", 32'(s_axis_tready), 32'd0);
    chk("midrst_hs", 32'(vga_hs_out), 32'd0);
    chk("midrst_vs", 32'(vga_vs_out), 32'd0);
    tick();
    chk("midrst_held_tready", 32'(s_axis_tready), 32'd0);
    rst_in = 1'b0;
    drive(1'b0, 1'b0, 24'h0, 1'b0, 11'd0, 10'd1);
    tick();
    chk("release_tready", 32'(s_axis_tready), 32'd1);
    chk("release_state", 32'(dut.state_q), 32'(HUNT));
    chk("release_empty", 32'(dut.fifo_empty), 32'd1);
    chk_pix("release", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Misalignment: SOF sits at pixel 500 of line 0.
    drive(1'b1, 1'b1, 24'hFF0000, 1'b0, 11'd1100, 10'd800);
    tick();
    drive(1'b1, 1'b0, 24'h00FF00, 1'b1, 11'd0, 10'd0);
    tick();
    chk_pix("mis_lock", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 11'd498, 10'd0);
    tick();
    chk_pix("mis_gap", 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 11'd499, 10'd0);
    tick();
    chk_pix("mis_499", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 11'd500, 10'd0);
    tick();
    chk_pix("mis_500", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("mis_empty", 32'(dut.fifo_empty), 32'd1);
    chk("mis_state", 32'(dut.state_q), 32'(HUNT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
